// File: rtl/l2_ecc_err_monitor.sv
// l2_ecc_err_monitor: passive ECC-error monitor on the L2 AXI R/B response path with a flat register port.
// Define L2_ECC_MON_IRQ_EN to build the threshold interrupt (THRESH, CTRL.irq_en, STATUS.irq_pend, IRQ state).
module l2_ecc_err_monitor #(
   parameter int unsigned AxiIdWidth   = 5,
   parameter int unsigned AxiUserWidth = 1,
   parameter int unsigned EccErrBit    = 0,
   parameter int unsigned CntWidth     = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    r_valid_i,
   input  logic                    r_ready_i,
   input  logic [AxiIdWidth-1:0]   r_id_i,
   input  logic [AxiUserWidth-1:0] r_user_i,
   input  logic                    b_valid_i,
   input  logic                    b_ready_i,
   input  logic [AxiIdWidth-1:0]   b_id_i,
   input  logic [AxiUserWidth-1:0] b_user_i,
   input  logic                    reg_valid_i,
   input  logic                    reg_write_i,
   input  logic [4:0]              reg_addr_i,
   input  logic [31:0]             reg_wdata_i,
   output logic                    reg_ready_o,
   output logic [31:0]             reg_rdata_o,
   output logic                    reg_error_o,
   output logic                    ecc_error_o,
   output logic                    irq_o
);

   typedef enum logic [1:0] {
      ARMED    = 2'd0,
      CAPTURED = 2'd1,
      IRQ      = 2'd2
   } state_e;

   localparam logic [4:0] ADDR_STATUS = 5'h00;
   localparam logic [4:0] ADDR_R_CNT  = 5'h04;
   localparam logic [4:0] ADDR_B_CNT  = 5'h08;
   localparam logic [4:0] ADDR_FIRST  = 5'h0C;
   localparam logic [4:0] ADDR_THRESH = 5'h10;
   localparam logic [4:0] ADDR_CTRL   = 5'h14;
   localparam logic [4:0] ADDR_CLEAR  = 5'h18;

   function automatic logic is_sat(input logic [CntWidth-1:0] v);
      return &v;
   endfunction

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
      return is_sat(v) ? v : v + CntWidth'(1);
   endfunction

   logic                  r_evt, b_evt;
   logic                  req_acc, addr_ok, clr;
   logic                  en_q;
   logic [CntWidth-1:0]   r_cnt_q, b_cnt_q;
   logic [CntWidth-1:0]   r_cnt_base, b_cnt_base;
   logic                  r_ovf_q, b_ovf_q;
   logic                  r_ovf_base, b_ovf_base;
   logic                  err_seen_q;
   logic                  irq_pend_q;
   logic                  irq_en_q;
   logic [CntWidth-1:0]   thresh_q;
   logic [AxiIdWidth-1:0] first_id_q;
   logic                  first_ch_q;
   state_e                state_q, state_base;
   logic [31:0]           rd_val;
   logic                  unused_in;

   assign unused_in = ^{reg_wdata_i, r_user_i, b_user_i};

   assign r_evt = en_q & r_valid_i & r_ready_i & r_user_i[EccErrBit];
   assign b_evt = en_q & b_valid_i & b_ready_i & b_user_i[EccErrBit];

   // A request is taken only when no completion pulse is on the bus, giving one idle cycle per access.
   assign req_acc = reg_valid_i & ~reg_ready_o;
   assign addr_ok = (reg_addr_i[1:0] == 2'b00) && (reg_addr_i <= ADDR_CLEAR);
   assign clr     = req_acc & reg_write_i & (reg_addr_i == ADDR_CLEAR);

   // CLEAR takes effect before any event of the same cycle is accounted.
   assign r_cnt_base = clr ? '0 : r_cnt_q;
   assign b_cnt_base = clr ? '0 : b_cnt_q;
   assign r_ovf_base = clr ? 1'b0 : r_ovf_q;
   assign b_ovf_base = clr ? 1'b0 : b_ovf_q;
   assign state_base = clr ? ARMED : state_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cnt_q <= '0;
         b_cnt_q <= '0;
         r_ovf_q <= 1'b0;
         b_ovf_q <= 1'b0;
      end else begin
         r_cnt_q <= r_evt ? sat_inc(r_cnt_base) : r_cnt_base;
         b_cnt_q <= b_evt ? sat_inc(b_cnt_base) : b_cnt_base;
         r_ovf_q <= r_ovf_base | (r_evt & is_sat(r_cnt_base));
         b_ovf_q <= b_ovf_base | (b_evt & is_sat(b_cnt_base));
      end
   end

`ifdef L2_ECC_MON_IRQ_EN
   logic [CntWidth:0] cnt_sum;
   logic              thr_hit;

   // Sum is one bit wider than the counters so two saturated counters never wrap.
   assign cnt_sum = {1'b0, r_cnt_q} + {1'b0, b_cnt_q};
   assign thr_hit = irq_en_q && (thresh_q != '0) && (cnt_sum >= {1'b0, thresh_q});
   assign irq_o   = irq_pend_q & irq_en_q;
`else
   assign irq_pend_q = 1'b0;
   assign irq_en_q   = 1'b0;
   assign thresh_q   = '0;
   assign irq_o      = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ARMED;
         err_seen_q <= 1'b0;
         first_id_q <= '0;
         first_ch_q <= 1'b0;
`ifdef L2_ECC_MON_IRQ_EN
         irq_pend_q <= 1'b0;
`endif
      end else begin
         if (clr) begin
            state_q    <= ARMED;
            err_seen_q <= 1'b0;
            first_id_q <= '0;
            first_ch_q <= 1'b0;
`ifdef L2_ECC_MON_IRQ_EN
            irq_pend_q <= 1'b0;
`endif
         end
         case (state_base)
            ARMED: begin
               if (r_evt | b_evt) begin
                  state_q    <= CAPTURED;
                  err_seen_q <= 1'b1;
                  first_id_q <= r_evt ? r_id_i : b_id_i;
                  first_ch_q <= ~r_evt;
               end
            end
            CAPTURED: begin
`ifdef L2_ECC_MON_IRQ_EN
               if (thr_hit) begin
                  state_q    <= IRQ;
                  irq_pend_q <= 1'b1;
               end
`endif
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         en_q <= 1'b0;
`ifdef L2_ECC_MON_IRQ_EN
         irq_en_q <= 1'b0;
         thresh_q <= '0;
`endif
      end else if (req_acc && reg_write_i) begin
         case (reg_addr_i)
            ADDR_CTRL: begin
               en_q <= reg_wdata_i[0];
`ifdef L2_ECC_MON_IRQ_EN
               irq_en_q <= reg_wdata_i[1];
`endif
            end
`ifdef L2_ECC_MON_IRQ_EN
            ADDR_THRESH: thresh_q <= reg_wdata_i[CntWidth-1:0];
`endif
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      case (reg_addr_i)
         ADDR_STATUS: rd_val[3:0] = {irq_pend_q, b_ovf_q, r_ovf_q, err_seen_q};
         ADDR_R_CNT:  rd_val[CntWidth-1:0] = r_cnt_q;
         ADDR_B_CNT:  rd_val[CntWidth-1:0] = b_cnt_q;
         ADDR_FIRST: begin
            rd_val[AxiIdWidth-1:0] = first_id_q;
            rd_val[31]             = first_ch_q;
         end
         ADDR_THRESH: rd_val[CntWidth-1:0] = thresh_q;
         ADDR_CTRL:   rd_val[1:0] = {irq_en_q, en_q};
         default: begin
         end
      endcase
   end

   // Response stage: read data is captured at the sampling edge and presented for one cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         reg_ready_o <= 1'b0;
         reg_rdata_o <= '0;
         reg_error_o <= 1'b0;
      end else begin
         reg_ready_o <= req_acc;
         reg_error_o <= req_acc & ~addr_ok;
         reg_rdata_o <= (req_acc && !reg_write_i && addr_ok) ? rd_val : '0;
      end
   end

   assign ecc_error_o = err_seen_q;

endmodule

// File: doc/l2_ecc_err_monitor.md
# l2_ecc_err_monitor

Passive monitor on the synchronous AXI response path between the L2 memory subsystem and its CDC destination. It watches R and B handshakes for the ECC-error user bit raised by the L2 controller. It counts errors per channel, latches the ID and channel of the first error, and raises a threshold interrupt. Software reads and clears it over a flat 32-bit register port. It feeds the currently tied-off L2 error line into the interrupt fabric.

## Interface
- AxiIdWidth, 5, AXI ID width of monitored responses
- AxiUserWidth, 1, AXI user width
- EccErrBit, 0, user bit index flagging an ECC error; must be < AxiUserWidth
- CntWidth, 16, width of each saturating error counter (2..32)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- r_valid_i  in  1  monitored R valid
- r_ready_i  in  1  monitored R ready
- r_id_i  in  AxiIdWidth  monitored R ID
- r_user_i  in  AxiUserWidth  monitored R user
- b_valid_i  in  1  monitored B valid
- b_ready_i  in  1  monitored B ready
- b_id_i  in  AxiIdWidth  monitored B ID
- b_user_i  in  AxiUserWidth  monitored B user
- reg_valid_i  in  1  register request valid
- reg_write_i  in  1  1 = write, 0 = read
- reg_addr_i  in  5  byte address, word aligned
- reg_wdata_i  in  32  write data
- reg_ready_o  out  1  one-cycle completion pulse
- reg_rdata_o  out  32  read data, valid with reg_ready_o
- reg_error_o  out  1  unmapped or unaligned address, valid with reg_ready_o
- ecc_error_o  out  1  level: any error latched since last clear
- irq_o  out  1  level interrupt

## Operation
- Error event, R channel: r_valid_i & r_ready_i & r_user_i[EccErrBit]. Every beat counts, not only last.
- Error event, B channel: b_valid_i & b_ready_i & b_user_i[EccErrBit].
- Monitoring is gated by CTRL.en. When en=0, events are ignored.
- Register map:
  - 0x00 STATUS (RO): [0] err_seen, [1] r_ovf, [2] b_ovf, [3] irq_pend.
  - 0x04 R_CNT (RO), zero-extended.
  - 0x08 B_CNT (RO), zero-extended.
  - 0x0C FIRST (RO): [AxiIdWidth-1:0] id, [31] channel (1 = B).
  - 0x10 THRESH (RW, CntWidth bits).
  - 0x14 CTRL (RW): [0] en, [1] irq_en.
  - 0x18 CLEAR (WO): write any value to clear counters, STATUS and FIRST. Reads return 0.
- Writes to RO registers are ignored and reg_error_o=0. Addresses >0x18 or unaligned give reg_error_o=1 and rdata 0.
- Counters saturate at all-ones. An event while saturated sets the corresponding ovf bit.
- FSM states:
  - ARMED: first event latches FIRST and sets err_seen, then moves to CAPTURED.
  - CAPTURED: when (R_CNT + B_CNT) ≥ THRESH, THRESH ≠ 0 and irq_en=1, set irq_pend and move to IRQ.
  - IRQ: stays until CLEAR. The sum is computed CntWidth+1 wide, with no wrap.
  - CLEAR in any state moves to ARMED.
- Simultaneous R and B events: both counters increment. FIRST records the R event.
- CLEAR in the same cycle as an event: the clear applies first, then the event is counted. Result: count=1, FIRST latched, state CAPTURED.
- irq_o = irq_pend & irq_en. Clearing irq_en masks irq_o without clearing irq_pend.
- ecc_error_o = err_seen.

## Timing
- Reset values:
  - All counters, STATUS, FIRST, THRESH and CTRL are 0; state ARMED.
  - reg_ready_o=0, reg_rdata_o=0, reg_error_o=0, ecc_error_o=0, irq_o=0.
- Event to counter update: 1 cycle. Event to ecc_error_o high: 1 cycle. Event to irq_o high: 2 cycles (counter update, then compare).
- Register access:
  - A request is sampled when reg_valid_i=1 and no access is pending.
  - reg_ready_o pulses for exactly one cycle, the following cycle, with rdata and error.
  - The cycle after the pulse is idle; minimum 2 cycles per access.
  - Reads return values as of the sampling edge.
- Reset asserted mid-access drops the access; reg_ready_o is 0 on the next cycle.

## Configuration
- L2_ECC_MON_IRQ_EN defined: THRESH, irq_en, irq_pend and the IRQ state are present as above.
- Not defined: irq_o tied 0. THRESH, CTRL[1] and STATUS[3] read 0 and writes to them are ignored. The FSM never leaves CAPTURED except on CLEAR. Counting and FIRST capture are unchanged.

## Test plan
- Reset then read all registers: all 0, reg_error_o=0; read 0x1C gives reg_error_o=1.
- en=1, three R error beats id=5, then one B error id=2: R_CNT=3, B_CNT=1, FIRST=0x00000005, ecc_error_o=1.
- CntWidth=2, five R errors: R_CNT=3, STATUS.r_ovf=1.
- THRESH=4, irq_en=1, four errors: irq_o high 2 cycles after the 4th event. CLEAR: irq_o=0, counts 0, state ARMED.
- Same-cycle R error id=1 and B error id=7: both counts 1, FIRST.id=1, channel=0.
- CLEAR coincident with an R error: R_CNT=1, err_seen=1. With the macro undefined, irq_o stays 0 after 10 errors and THRESH=1.
